// File: rtl/vga_scanout.sv
// vga_scanout: raster timing, VRAM read addressing and RGB332 to RGB444
// expansion, with a 2-clock address-to-pin pipeline.
module vga_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic        clk_vga,
   input  logic        rst_n,
   input  logic [19:0] fb_base,
   output logic [19:0] vga_addr,
   input  logic [7:0]  vga_pixel_out,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_de,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0]  h_q, h_d, v_q, v_d;
   logic [19:0] base_q, base_d, addr_q, addr_d;
   logic        act1_q, act1_d, hs1_q, hs1_d;
   logic        vs1_q, vs1_d, fs1_q, fs1_d;
   logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
   logic [3:0]  r_q, r_d, g_q, g_d, b_q, b_d;
   logic        h_end, v_end, wrap;

   always_comb begin
      h_end  = (h_q == H_LAST);
      v_end  = (v_q == V_LAST);
      wrap   = h_end && v_end;
      h_d    = h_end ? '0 : h_q + 10'd1;
      v_d    = v_q;
      if (h_end) begin
         v_d = v_end ? '0 : v_q + 10'd1;
      end
      base_d = wrap ? fb_base : base_q;

      act1_d = (h_q < H_ACT) && (v_q < V_ACT);
      hs1_d  = (h_q >= HS_BEG) && (h_q < HS_END);
      vs1_d  = (v_q >= VS_BEG) && (v_q < VS_END);
      fs1_d  = (h_q == '0) && (v_q == '0);

      // Blanking holds the address: it already points at the next line.
      addr_d = addr_q;
      if (wrap) begin
         addr_d = base_d;
      end else if (act1_d) begin
         addr_d = addr_q + 20'd1;
      end

      de_d = act1_q;
      hs_d = hs1_q ? HS_POL : ~HS_POL;
      vs_d = vs1_q ? VS_POL : ~VS_POL;
      fs_d = fs1_q;
      r_d  = '0;
      g_d  = '0;
      b_d  = '0;
      if (act1_q) begin
         r_d = {vga_pixel_out[7:5], vga_pixel_out[7]};
         g_d = {vga_pixel_out[4:2], vga_pixel_out[4]};
         b_d = {vga_pixel_out[1:0], vga_pixel_out[1:0]};
      end
   end

   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         h_q    <= '0;
         v_q    <= '0;
         base_q <= '0;
         addr_q <= '0;
         act1_q <= 1'b0;
         hs1_q  <= 1'b0;
         vs1_q  <= 1'b0;
         fs1_q  <= 1'b0;
         de_q   <= 1'b0;
         hs_q   <= ~HS_POL;
         vs_q   <= ~VS_POL;
         fs_q   <= 1'b0;
         r_q    <= '0;
         g_q    <= '0;
         b_q    <= '0;
      end else begin
         h_q    <= h_d;
         v_q    <= v_d;
         base_q <= base_d;
         addr_q <= addr_d;
         act1_q <= act1_d;
         hs1_q  <= hs1_d;
         vs1_q  <= vs1_d;
         fs1_q  <= fs1_d;
         de_q   <= de_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         fs_q   <= fs_d;
         r_q    <= r_d;
         g_q    <= g_d;
         b_q    <= b_d;
      end
   end

   assign vga_addr    = addr_q;
   assign vga_de      = de_q;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign frame_start = fs_q;
   assign vga_r       = r_q;
   assign vga_g       = g_q;
   assign vga_b       = b_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: cycle-level reference model of the raster, plus colour
// vectors, double-buffer, wrap-around and reset sequences.
module tb_vga_scanout;

   localparam int HA  = 640;
   localparam int HF  = 16;
   localparam int HSW = 96;
   localparam int HBP = 48;
   localparam int VA  = 4;
   localparam int VF  = 2;
   localparam int VSW = 2;
   localparam int VBP = 3;
   localparam int HT  = HA + HF + HSW + HBP;
   localparam int VT  = VA + VF + VSW + VBP;
   localparam int FT  = HT * VT;

   logic        clk_vga = 1'b0;
   logic        rst_n;
   logic [19:0] fb_base = '0;
   logic [19:0] vga_addr;
   logic [7:0]  vga_pixel_out = '0;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_de, frame_start;

   int errors = 0;
   int checks = 0;

   always #5 clk_vga = ~clk_vga;

   vga_scanout #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VBP),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut (
      .clk_vga(clk_vga),
      .rst_n(rst_n),
      .fb_base(fb_base),
      .vga_addr(vga_addr),
      .vga_pixel_out(vga_pixel_out),
      .vga_r(vga_r),
      .vga_g(vga_g),
      .vga_b(vga_b),
      .vga_hs(vga_hs),
      .vga_vs(vga_vs),
      .vga_de(vga_de),
      .frame_start(frame_start)
   );

   typedef struct {
      int         cyc;
      logic [7:0] pix;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
      logic       de;
   } vec_t;

   vec_t        vec [7];
   logic [19:0] plan [4];

   int          t;
   logic [19:0] cur_base, fb_prev;
   logic [7:0]  last_pix;
   int de_cnt, de_first, hs_cnt, hs_first;
   int vs_cnt, vs_first, fs_cnt, fs_last;

   function automatic logic [19:0] exp_addr(int p, logic [19:0] b);
      int h, v;
      h = p % HT;
      v = p / HT;
      if (v < VA) return b + 20'(v * HA + ((h < HA) ? h : HA));
      return b + 20'(HA * VA);
   endfunction

   function automatic logic [15:0] exp_pins(int tt, logic [7:0] px);
      int p, h, v, pv, ri, gi, bi;
      logic act, hsr, vsr;
      if (tt < 2) return 16'h6000;
      p   = (tt - 2) % FT;
      h   = p % HT;
      v   = p / HT;
      act = (h < HA) && (v < VA);
      hsr = (h >= HA + HF) && (h < HA + HF + HSW);
      vsr = (v >= VA + VF) && (v < VA + VF + VSW);
      pv  = int'(px);
      ri  = (pv >> 5) * 2 + (pv >> 7);
      gi  = ((pv >> 2) & 7) * 2 + ((pv >> 4) & 1);
      bi  = (pv & 3) * 4 + (pv & 3);
      if (!act) begin
         ri = 0;
         gi = 0;
         bi = 0;
      end
      return {act, !hsr, !vsr, p == 0, 4'(ri), 4'(gi), 4'(bi)};
   endfunction

   task automatic check(input string name, input logic [35:0] got,
                        input logic [35:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at t=%0d: got %0h, expected %0h",
                  name, t, got, exp);
      end
   endtask

   task automatic check_reset(input string name);
      check(name,
            {vga_addr, vga_de, vga_hs, vga_vs, frame_start,
             vga_r, vga_g, vga_b},
            {20'h0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h0});
   endtask

   task automatic hand_checks();
      if (t == 0)          check("addr_start", 36'(vga_addr), 36'(0));
      if (t == 639)        check("addr_639", 36'(vga_addr), 36'(639));
      if (t == 700)        check("addr_hblank", 36'(vga_addr), 36'(640));
      if (t == 801)        check("addr_line1", 36'(vga_addr), 36'(641));
      if (t == FT - 1)     check("addr_vblank", 36'(vga_addr), 36'(HA * VA));
      if (t == FT)         check("frame1_base", 36'(vga_addr), 36'h80000);
      if (t == 2*FT + 255) check("wrap_hi", 36'(vga_addr), 36'hFFFFF);
      if (t == 2*FT + 256) check("wrap_lo", 36'(vga_addr), 36'h00000);
   endtask

   task automatic do_cycle();
      logic [7:0] px;
      if (t > 0 && t % FT == 0) cur_base = fb_prev;
      check("addr", 36'(vga_addr), 36'(exp_addr(t % FT, cur_base)));
      check("pins",
            36'({vga_de, vga_hs, vga_vs, frame_start, vga_r, vga_g, vga_b}),
            36'(exp_pins(t, last_pix)));
      foreach (vec[k]) begin
         if (vec[k].cyc == t - 1) begin
            check("colour", 36'({vga_de, vga_r, vga_g, vga_b}),
                  36'({vec[k].de, vec[k].r, vec[k].g, vec[k].b}));
         end
      end
      if (t >= 2 && t <= HT + 1) begin
         if (vga_de) begin
            de_cnt++;
            if (de_first < 0) de_first = t;
         end
         if (!vga_hs) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = t;
         end
      end
      if (t >= 2 && t <= FT + 1 && !vga_vs) begin
         vs_cnt++;
         if (vs_first < 0) vs_first = t;
      end
      if (frame_start) begin
         fs_cnt++;
         if (fs_last >= 0) check("fs_period", 36'(t - fs_last), 36'(FT));
         fs_last = t;
      end
      hand_checks();
      px = 8'($urandom);
      foreach (vec[k]) if (vec[k].cyc == t) px = vec[k].pix;
      vga_pixel_out = px;
      last_pix      = px;
      fb_base = (t % FT == FT - 1) ? plan[t / FT + 1] : 20'($urandom);
      fb_prev = fb_base;
   endtask

   task automatic release_reset();
      @(posedge clk_vga);
      #1;
      rst_n    = 1'b1;
      t        = 0;
      cur_base = '0;
      last_pix = '0;
      do_cycle();
   endtask

   initial begin
      vec[0] = '{5,   8'hE0, 4'hF, 4'h0, 4'h0, 1'b1};
      vec[1] = '{6,   8'h1C, 4'h0, 4'hF, 4'h0, 1'b1};
      vec[2] = '{7,   8'h03, 4'h0, 4'h0, 4'hF, 1'b1};
      vec[3] = '{8,   8'h92, 4'h9, 4'h9, 4'hA, 1'b1};
      vec[4] = '{9,   8'hFF, 4'hF, 4'hF, 4'hF, 1'b1};
      vec[5] = '{10,  8'h00, 4'h0, 4'h0, 4'h0, 1'b1};
      vec[6] = '{700, 8'hFF, 4'h0, 4'h0, 4'h0, 1'b0};
      plan[0] = 20'h00000;
      plan[1] = 20'h80000;
      plan[2] = 20'hFFF00;
      plan[3] = 20'($urandom);
      de_cnt = 0; de_first = -1; hs_cnt = 0; hs_first = -1;
      vs_cnt = 0; vs_first = -1; fs_cnt = 0; fs_last  = -1;
      t = 0;

      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) begin
         @(posedge clk_vga);
         #1;
         vga_pixel_out = 8'($urandom);
         fb_base       = 20'($urandom);
         #1 check_reset("reset_hold");
      end

      release_reset();
      while (t < 3*FT + 2*HT + 300) begin
         @(posedge clk_vga);
         #1;
         t++;
         do_cycle();
      end

      check("de_count", 36'(de_cnt), 36'(HA));
      check("de_first", 36'(de_first), 36'(2));
      check("hs_count", 36'(hs_cnt), 36'(HSW));
      check("hs_first", 36'(hs_first), 36'(2 + HA + HF));
      check("vs_count", 36'(vs_cnt), 36'(VSW * HT));
      check("vs_first", 36'(vs_first), 36'(2 + (VA + VF) * HT));
      check("fs_count", 36'(fs_cnt), 36'(4));

      #3 rst_n = 1'b0;
      #1 check_reset("async_reset");
      repeat (2) begin
         @(posedge clk_vga);
         #1;
         vga_pixel_out = 8'($urandom);
         #1 check_reset("reset_mid");
      end

      fs_last = -1;
      release_reset();
      while (t < 900) begin
         @(posedge clk_vga);
         #1;
         t++;
         do_cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

VGA display controller on the `clk_vga` domain, directly downstream of the dual-port VRAM read port. It generates 640x480@60 raster timing and issues one read address per pixel clock on `vga_addr`. It takes the 8-bit RGB332 pixel returned one cycle later on `vga_pixel_out`, expands it to 4-bit-per-channel RGB, and drives it to the DAC/pins with matching sync and data-enable. Frame-buffer base switching (double buffering) is supported and takes effect only at frame boundaries.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixel clocks)
- `H_SYNC`, 96, hsync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width
- `V_BP`, 33, vertical back porch
- `HS_POL`, 0, hsync active level (0 = active-low)
- `VS_POL`, 0, vsync active level

Ports:
- `clk_vga`  in  1  pixel clock. This is the only clock.
- `rst_n`  in  1  asynchronous, active-low reset
- `fb_base`  in  20  frame-buffer base byte address, sampled at frame boundary
- `vga_addr`  out  20  VRAM read address (to VRAM `vga_addr`)
- `vga_pixel_out`  in  8  VRAM read data, RGB332, valid the cycle after the address
- `vga_r`, `vga_g`, `vga_b`  out  4 each  colour outputs
- `vga_hs`, `vga_vs`  out  1  sync outputs
- `vga_de`  out  1  active-video flag, aligned with colour
- `frame_start`  out  1  one-cycle pulse, aligned with output of pixel (0,0)

## Operation
- Counters:
  - `h` counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - `v` counts 0..V_TOTAL-1 (525).
  - `h` increments every clock. At H_TOTAL-1 it wraps to 0 and `v` increments. At (H_TOTAL-1, V_TOTAL-1) both wrap to 0.
- Base latch: `base_q` loads `fb_base` on the clock where the counters wrap to (0,0). A `fb_base` change at any other time has no effect on the current frame.
- Address, registered and consistent with the counter position (h,v) in the same cycle. All arithmetic is mod 2^20, with wrap-around allowed.
  - If v < V_ACTIVE: `vga_addr` = base_q + v·H_ACTIVE + min(h, H_ACTIVE). During horizontal blank it therefore holds the first address of line v+1.
  - If v ≥ V_ACTIVE: `vga_addr` = base_q + H_ACTIVE·V_ACTIVE, held constant.
  - Implement with an incrementing register, not a multiplier.
- Active region: `active` = (h < H_ACTIVE) && (v < V_ACTIVE).
- Sync regions (raw):
  - `hs_raw` = H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - `vs_raw` = V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, i.e. lines 490..491.
  - Output level = raw ? POL : ~POL.
- Colour expansion from pixel p:
  - r = {p[7:5], p[7]}
  - g = {p[4:2], p[4]}
  - b = {p[1:0], p[1:0]}
  - When `de` is 0, r, g and b are forced to 0.
- `frame_start` = 1 exactly for the output cycle of position (0,0).

## Timing
- Pipeline:
  - Cycle n: counters = P and `vga_addr` = addr(P).
  - VRAM registers data at the end of cycle n.
  - Data is valid on `vga_pixel_out` during cycle n+1.
  - The block registers colour, `vga_de`, `vga_hs`, `vga_vs` and `frame_start` at the end of cycle n+1.
  - These outputs are valid during cycle n+2.
- Total latency from address to pixel pins is 2 clocks. `active`, `hs_raw`, `vs_raw` and the frame flag are delayed through 2 register stages so all outputs are mutually aligned.
- Reset (async assert, release synchronous to `clk_vga`):
  - h = v = 0, base_q = 0, `vga_addr` = 0.
  - Both delay stages are cleared: `vga_de` = 0, r = g = b = 0, `frame_start` = 0.
  - `vga_hs` = ~HS_POL and `vga_vs` = ~VS_POL (inactive).
- The first frame after reset uses base 0. The first `frame_start` is output 2 clocks after reset release, and the pipeline stage 1 bubble shows as blank.
- Reset mid-frame: all state returns to reset values immediately. The raster restarts at (0,0) with no partial-line recovery.
- Frame period = 800·525 = 420000 clocks.

## Test plan
- Reset check: hold `rst_n`=0 with an arbitrary `vga_pixel_out` → `vga_addr`=0, `vga_de`=0, rgb=0, `vga_hs`=`vga_vs`=1, `frame_start`=0. After release, `vga_addr` steps 0,1,…,639, then holds 640 for h=640..799, then 641 at line 1 h=1.
- Horizontal timing: count clocks on line 0 → `vga_de`=1 for 640 clocks starting 2 clocks after h=0, `vga_hs`=0 for 96 clocks starting at output h=656. Period is 800 clocks.
- Vertical timing: `vga_vs`=0 for exactly 2 lines (output lines 490–491). `vga_de` stays 0 for lines 480–524. `vga_addr`=307200 through vblank. `frame_start` pulses once every 420000 clocks.
- Colour expansion, fed from a VRAM model:
  - pixel 0xE0 → r=F, g=0, b=0
  - pixel 0x1C → r=0, g=F, b=0
  - pixel 0x03 → r=0, g=0, b=F
  - pixel 0x92 → r=9, g=9, b=A
  - any pixel in blank → rgb=0
- Double buffer: change `fb_base` to 0x80000 mid-frame → addresses for the current frame are unchanged. The next frame's first `vga_addr` is 0x80000. With base 0xFFF00, addresses wrap through 0xFFFFF to 0x00000.
- Reset mid-frame: assert `rst_n` at line 200, h=300 → outputs reach reset values within the same cycle (async). After release the raster restarts at (0,0) with `vga_addr`=0.
